meep_uart_lite: RTL and testbench
=================================

# meep_uart_lite

AXI4-Lite UART peripheral that consumes the shell's 13-bit / 32-bit UART register port and produces the UART interrupt line. It holds a TX FIFO feeding an 8N1 serializer, an RX deserializer feeding an RX FIFO, and a status/control register pair. It sits in the chipset clock domain between the shell's UART AXI-Lite master port and the board UART pins.

## Interface
- DIV, 434: chipset_clk cycles per bit; legal range 16..65535.
- FIFO_DEPTH, 16: entries per FIFO, power of two, 2..256.

Ports (clock and reset first):
- chipset_clk  in  1  sole clock
- chipset_rst_n  in  1  synchronous active-low reset
- s_axi_awaddr  in  13  write address
- s_axi_awvalid / s_axi_awready  in / out  1  write-address handshake
- s_axi_wdata  in  32  write data; no strobes, always full-word
- s_axi_wvalid / s_axi_wready  in / out  1  write-data handshake
- s_axi_bresp  out  2  write response
- s_axi_bvalid / s_axi_bready  out / in  1  write-response handshake
- s_axi_araddr  in  13  read address
- s_axi_arvalid / s_axi_arready  in / out  1  read-address handshake
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid / s_axi_rready  out / in  1  read-data handshake
- uart_rx  in  1  asynchronous serial input
- uart_tx  out  1  serial output, idle high
- uart_irq  out  1  level interrupt

## Operation
- Decode on awaddr/araddr[3:2]; [1:0] ignored. Any [12:4] bit set gives SLVERR (2'b10): no side effect, rdata 0. Otherwise OKAY.
- 0x0 RXDATA (R): rdata[7:0] is the RX FIFO head, and the read pops it. If the FIFO is empty, rdata is 0 and nothing is popped. Writes are ignored.
- 0x4 TXDATA (W): pushes wdata[7:0]. If the FIFO is full, the byte is dropped and the response is still OKAY. Reads return 0.
- 0x8 STAT (R): bit0 rx_valid, bit1 rx_full, bit2 tx_empty, bit3 tx_full, bit4 intr_en, bit5 overrun, bit6 frame_err, bit7 tx_done. A read clears bits 5, 6 and 7 in the capture cycle. Writes are ignored.
- 0xC CTRL (W): bit0 flushes the TX FIFO; bit1 flushes the RX FIFO; bit4 is stored as intr_en. Bits 0 and 1 are self-clearing. Reads return 0.
- Write FSM: W_IDLE → W_ACK when awvalid&wvalid are both high. The FSM never accepts one channel without the other. In W_ACK, awready=wready=1 for exactly one cycle and the register side effect commits. Then W_RESP holds bvalid=1 until bready, then returns to W_IDLE.
- Read FSM: R_IDLE → R_ACK on arvalid. In R_ACK, arready=1 for one cycle and rdata/rresp are captured along with the pop or clear. Then R_RESP holds rvalid=1 with rdata stable until rready.
- The read and write FSMs run independently. A concurrent TX push and RX pop are both honoured.
- TX: idle high. When the shifter is idle and the FIFO is non-empty, pop one byte and send 1 start bit (0), 8 data bits LSB first, then 1 stop bit (1). Each bit lasts DIV cycles. The next frame starts immediately with no gap.
- tx_done sets on the cycle a stop bit ends with the FIFO empty. It is cleared by a STAT read or a TXDATA write.
- RX: uart_rx passes through a 2-flop synchronizer. In idle, a sampled 0 starts a frame. At DIV/2 the bit is rechecked; a 1 is a false start and returns to idle. After that, 8 data samples are taken every DIV cycles, then one stop sample.
- Stop sample 0: set frame_err and discard the byte. FIFO full: set overrun and discard the byte. Otherwise push the byte.
- uart_irq = intr_en & (rx_valid | tx_done), registered.

## Timing
- Reset values: all ready/valid outputs 0, bresp/rresp 0, rdata 0, uart_tx 1, uart_irq 0. Both FIFOs are empty, all flags are 0, intr_en is 0.
- Write latency: both valids high at cycle 0 → awready/wready at cycle 1 → bvalid at cycle 2 at the earliest. The pushed byte is visible in STAT at cycle 2.
- Read latency: arvalid at cycle 0 → arready at cycle 1 → rvalid at cycle 2.
- TX latency: a push into an empty FIFO with an idle shifter drives uart_tx low 2 cycles after the W_ACK edge. A frame lasts exactly 10·DIV cycles.
- Reset mid-frame: uart_tx returns to 1 on the next edge, and the partial RX byte is discarded.
- CTRL flush during a TX frame: the current frame completes and queued bytes are discarded.
- CTRL flush of RX in the same cycle as an RX push: the flush wins and the FIFO is empty.
- FIFO wrap-around uses log2(FIFO_DEPTH)+1-bit pointers. Full means the MSBs differ and the remaining bits are equal.

## Test plan
- Reset check: drive chipset_rst_n=0 for 3 cycles → uart_tx=1, uart_irq=0, STAT reads 0x04.
- TX, DIV=16: write 0x4 with 0xA5 → uart_tx shows 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles. STAT then reads 0x84; a second STAT read returns 0x04.
- RX: drive the frame for 0x3C, then read 0x0 → rdata 0x3C. With intr_en=1, uart_irq is high before the pop and low 1 cycle after R_ACK.
- RX overflow: receive FIFO_DEPTH+1 bytes → STAT bits0,1,5 set. RXDATA returns the first FIFO_DEPTH bytes in order; the last byte is lost.
- Errors: an RX frame with stop bit 0 → frame_err=1 and no push. A 0.25·DIV low glitch → no frame. Write to 0x10 → bresp 2'b10 and no state change.
- Handshake stress: hold bready low for 20 cycles → bvalid stays high and awready is not reasserted. With awvalid high but wvalid low → awready stays 0.

Source files
------------

// File: rtl/meep_uart_lite.sv
// rtl/meep_uart_lite.sv - AXI4-Lite UART: TX/RX FIFOs, 8N1 serializer/deserializer, status/control, interrupt
module meep_uart_lite_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Flush outranks a same-cycle push or pop so the queue always ends up empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q[AW-1:0]] = push_data;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

module meep_uart_lite #(
    parameter int DIV        = 434,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        chipset_clk,
    input  logic        chipset_rst_n,
    input  logic [12:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [12:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        uart_irq
);
    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_RESP} r_state_e;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    localparam logic [15:0] DIV_M1      = 16'(DIV - 1);
    localparam logic [15:0] HALF_M1     = 16'(DIV / 2 - 1);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  A_RXDATA    = 2'd0;
    localparam logic [1:0]  A_TXDATA    = 2'd1;
    localparam logic [1:0]  A_STAT      = 2'd2;
    localparam logic [1:0]  A_CTRL      = 2'd3;

    w_state_e    w_state_q, w_state_d;
    r_state_e    r_state_q, r_state_d;
    tx_state_e   tx_state_q, tx_state_d;
    rx_state_e   rx_state_q, rx_state_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic        intr_en_q, intr_en_d;
    logic        overrun_q, overrun_d;
    logic        frame_err_q, frame_err_d;
    logic        tx_done_q, tx_done_d;
    logic        irq_q, irq_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_q, tx_d;
    logic        rx_sync1_q, rx_sync1_d;
    logic        rx_sync2_q, rx_sync2_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;

    logic        wr_bad, rd_bad, w_commit, r_capture;
    logic [1:0]  wr_idx, rd_idx;
    logic        tx_push, tx_pop, tx_flush, tx_empty, tx_full, tx_avail;
    logic        rx_push, rx_pop, rx_flush, rx_empty, rx_full;
    logic [7:0]  tx_head, rx_head, stat;
    logic        ctrl_wr, stat_rd, tx_done_set, overrun_set, frame_err_set;
    logic        unused_bits;

    assign unused_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wdata[31:5], s_axi_wdata[3:2]};

    assign wr_bad    = |s_axi_awaddr[12:4];
    assign rd_bad    = |s_axi_araddr[12:4];
    assign wr_idx    = s_axi_awaddr[3:2];
    assign rd_idx    = s_axi_araddr[3:2];
    assign w_commit  = (w_state_q == W_ACK);
    assign r_capture = (r_state_q == R_ACK);
    assign tx_push   = w_commit && !wr_bad && (wr_idx == A_TXDATA);
    assign ctrl_wr   = w_commit && !wr_bad && (wr_idx == A_CTRL);
    assign tx_flush  = ctrl_wr && s_axi_wdata[0];
    assign rx_flush  = ctrl_wr && s_axi_wdata[1];
    assign rx_pop    = r_capture && !rd_bad && (rd_idx == A_RXDATA);
    assign stat_rd   = r_capture && !rd_bad && (rd_idx == A_STAT);
    assign tx_avail  = !tx_empty && !tx_flush;
    assign stat      = {tx_done_q, frame_err_q, overrun_q, intr_en_q, tx_full, tx_empty, rx_full, !rx_empty};

    meep_uart_lite_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk       (chipset_clk),
        .resetn    (chipset_rst_n),
        .flush     (tx_flush),
        .push      (tx_push),
        .push_data (s_axi_wdata[7:0]),
        .pop       (tx_pop),
        .head      (tx_head),
        .empty     (tx_empty),
        .full      (tx_full)
    );

    meep_uart_lite_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk       (chipset_clk),
        .resetn    (chipset_rst_n),
        .flush     (rx_flush),
        .push      (rx_push),
        .push_data (rx_shift_q),
        .pop       (rx_pop),
        .head      (rx_head),
        .empty     (rx_empty),
        .full      (rx_full)
    );

    // Write channel: address and data are only ever taken together.
    always_comb begin
        w_state_d     = w_state_q;
        bresp_d       = bresp_q;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (w_state_q)
            W_IDLE: if (s_axi_awvalid && s_axi_wvalid) w_state_d = W_ACK;
            W_ACK: begin
                s_axi_awready = 1'b1;
                s_axi_wready  = 1'b1;
                bresp_d       = wr_bad ? RESP_SLVERR : RESP_OKAY;
                w_state_d     = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d     = r_state_q;
        rdata_d       = rdata_q;
        rresp_d       = rresp_q;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        case (r_state_q)
            R_IDLE: if (s_axi_arvalid) r_state_d = R_ACK;
            R_ACK: begin
                s_axi_arready = 1'b1;
                rresp_d       = rd_bad ? RESP_SLVERR : RESP_OKAY;
                rdata_d       = 32'd0;
                if (!rd_bad) begin
                    case (rd_idx)
                        A_RXDATA: rdata_d = rx_empty ? 32'd0 : {24'd0, rx_head};
                        A_STAT:   rdata_d = {24'd0, stat};
                        default:  rdata_d = 32'd0;
                    endcase
                end
                r_state_d = R_RESP;
            end
            R_RESP: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Serializer; uart_tx is registered, so every bit lags the state by one cycle uniformly.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_pop      = 1'b0;
        tx_done_set = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_avail) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_cnt_d   = '0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == DIV_M1) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == DIV_M1) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                    else                  tx_bit_d   = tx_bit_q + 3'd1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == DIV_M1) begin
                    tx_cnt_d = '0;
                    if (tx_avail) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
                        tx_state_d = TX_START;
                    end else begin
                        tx_done_set = 1'b1;
                        tx_state_d  = TX_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        case (tx_state_q)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = tx_shift_q[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // Deserializer: start is confirmed at mid-bit, then every later sample lands mid-bit.
    always_comb begin
        rx_sync1_d    = uart_rx;
        rx_sync2_d    = rx_sync1_q;
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_cnt_q;
        rx_bit_d      = rx_bit_q;
        rx_shift_d    = rx_shift_q;
        rx_push       = 1'b0;
        overrun_set   = 1'b0;
        frame_err_set = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync2_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_M1) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == DIV_M1) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == DIV_M1) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    if (!rx_sync2_q)  frame_err_set = 1'b1;
                    else if (rx_full) overrun_set   = 1'b1;
                    else              rx_push       = 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Sticky flags: a fresh event in the clearing cycle is kept rather than lost.
    always_comb begin
        intr_en_d   = ctrl_wr ? s_axi_wdata[4] : intr_en_q;
        overrun_d   = (overrun_q && !stat_rd) || overrun_set;
        frame_err_d = (frame_err_q && !stat_rd) || frame_err_set;
        tx_done_d   = (tx_done_q && !stat_rd && !tx_push) || tx_done_set;
        irq_d       = intr_en_q && (!rx_empty || tx_done_q);
    end

    always_ff @(posedge chipset_clk) begin
        if (!chipset_rst_n) begin
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            tx_state_q  <= TX_IDLE;
            rx_state_q  <= RX_IDLE;
            bresp_q     <= RESP_OKAY;
            rresp_q     <= RESP_OKAY;
            rdata_q     <= '0;
            intr_en_q   <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            tx_done_q   <= 1'b0;
            irq_q       <= 1'b0;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_q        <= 1'b1;
            rx_sync1_q  <= 1'b1;
            rx_sync2_q  <= 1'b1;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
        end else begin
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            tx_state_q  <= tx_state_d;
            rx_state_q  <= rx_state_d;
            bresp_q     <= bresp_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
            intr_en_q   <= intr_en_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            tx_done_q   <= tx_done_d;
            irq_q       <= irq_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_q        <= tx_d;
            rx_sync1_q  <= rx_sync1_d;
            rx_sync2_q  <= rx_sync2_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
        end
    end

    assign s_axi_bresp = bresp_q;
    assign s_axi_rresp = rresp_q;
    assign s_axi_rdata = rdata_q;
    assign uart_tx     = tx_q;
    assign uart_irq    = irq_q;
endmodule

// File: tb/tb_meep_uart_lite.sv
// tb/tb_meep_uart_lite.sv - self-checking bench for meep_uart_lite
module tb_meep_uart_lite;
    localparam int DIV      = 16;
    localparam int DEPTH    = 4;
    localparam int WAIT_MAX = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [12:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [12:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        uart_rx = 1'b1;
    logic        uart_tx;
    logic        uart_irq;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int b_cyc = 0;

    meep_uart_lite #(.DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .chipset_clk   (clk),
        .chipset_rst_n (rst_n),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .uart_rx       (uart_rx),
        .uart_tx       (uart_tx),
        .uart_irq      (uart_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        wr;
        logic [12:0] addr;
        logic [31:0] wdata;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: no handshake within %0d cycles", name, WAIT_MAX);
    endtask

    task automatic axi_write(input logic [12:0] a, input logic [31:0] d, output logic [1:0] resp);
        int n;
        resp = 2'b11;
        @(negedge clk);
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while (!awready && n < WAIT_MAX) begin @(negedge clk); n++; end
        if (!awready) begin
            timeout("awready");
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < WAIT_MAX) begin @(negedge clk); n++; end
        if (!bvalid) begin
            timeout("bvalid");
            return;
        end
        b_cyc = cyc;
        resp = bresp;
        @(negedge clk);
    endtask

    task automatic axi_read(input logic [12:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        d = '1;
        resp = 2'b11;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!arready && n < WAIT_MAX) begin @(negedge clk); n++; end
        if (!arready) begin
            timeout("arready");
            arvalid = 1'b0;
            return;
        end
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < WAIT_MAX) begin @(negedge clk); n++; end
        if (!rvalid) begin
            timeout("rvalid");
            return;
        end
        d = rdata;
        resp = rresp;
        @(negedge clk);
    endtask

    task automatic read_expect(input string name, input logic [12:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(a, d, r);
        check(name, d, exp);
    endtask

    task automatic write_ok(input logic [12:0] a, input logic [31:0] d);
        logic [1:0] r;
        axi_write(a, d, r);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            uart_rx = f[i];
            repeat (DIV - 1) @(negedge clk);
        end
        @(negedge clk);
        uart_rx = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic [9:0]  frame;
        logic        first, last, ok;
        int          n;

        vecs[0]  = '{1'b0, 13'h0008, 32'h0,  2'b00, 32'h04};
        vecs[1]  = '{1'b0, 13'h0000, 32'h0,  2'b00, 32'h00};
        vecs[2]  = '{1'b0, 13'h0004, 32'h0,  2'b00, 32'h00};
        vecs[3]  = '{1'b0, 13'h000C, 32'h0,  2'b00, 32'h00};
        vecs[4]  = '{1'b0, 13'h0010, 32'h0,  2'b10, 32'h00};
        vecs[5]  = '{1'b1, 13'h0014, 32'h41, 2'b10, 32'h00};
        vecs[6]  = '{1'b1, 13'h0000, 32'h55, 2'b00, 32'h00};
        vecs[7]  = '{1'b1, 13'h000C, 32'h10, 2'b00, 32'h00};
        vecs[8]  = '{1'b0, 13'h0008, 32'h0,  2'b00, 32'h14};
        vecs[9]  = '{1'b0, 13'h1008, 32'h0,  2'b10, 32'h00};
        vecs[10] = '{1'b0, 13'h000B, 32'h0,  2'b00, 32'h14};
        vecs[11] = '{1'b1, 13'h000C, 32'h00, 2'b00, 32'h00};

        repeat (3) @(negedge clk);
        check("rst_uart_tx", uart_tx, 1);
        check("rst_uart_irq", uart_irq, 0);
        check("rst_handshakes", {awready, wready, bvalid, arready, rvalid}, 0);
        check("rst_resp_rdata", {bresp, rresp, rdata}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].wdata, r);
                check($sformatf("vec%0d_bresp", i), r, vecs[i].resp);
            end else begin
                axi_read(vecs[i].addr, d, r);
                check($sformatf("vec%0d_rresp", i), r, vecs[i].resp);
                check($sformatf("vec%0d_rdata", i), d, vecs[i].rdata);
            end
        end
        read_expect("stat_after_table", 13'h8, 32'h04);

        // TX of 0xA5: latency from the write response, then exact bit boundaries.
        axi_write(13'h4, 32'hA5, r);
        n = 0;
        while (uart_tx && n < WAIT_MAX) begin @(negedge clk); n++; end
        check("tx_latency", cyc - b_cyc, 2);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10; i++) begin
            first = uart_tx;
            repeat (DIV - 1) @(negedge clk);
            last = uart_tx;
            check($sformatf("tx_bit%0d", i), {first, last}, {2{frame[i]}});
            @(negedge clk);
        end
        read_expect("stat_tx_done", 13'h8, 32'h84);
        read_expect("stat_tx_done_cleared", 13'h8, 32'h04);
        check("irq_off_no_intr_en", uart_irq, 0);

        // RX with interrupt enabled.
        write_ok(13'hC, 32'h10);
        send_rx(8'h3C, 1'b1);
        repeat (3) @(negedge clk);
        check("irq_rx_valid", uart_irq, 1);
        read_expect("stat_rx_valid", 13'h8, 32'h15);
        read_expect("rxdata_3c", 13'h0, 32'h3C);
        check("irq_after_pop", uart_irq, 0);
        write_ok(13'hC, 32'h00);

        send_rx(8'h55, 1'b0);
        repeat (20) @(negedge clk);
        read_expect("stat_frame_err", 13'h8, 32'h44);
        read_expect("stat_frame_err_cleared", 13'h8, 32'h04);

        @(negedge clk);
        uart_rx = 1'b0;
        repeat (DIV / 4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (300) @(negedge clk);
        read_expect("stat_glitch", 13'h8, 32'h04);

        // Overflow: DEPTH+1 bytes, last one lost.
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        send_rx(8'h33, 1'b1);
        send_rx(8'h44, 1'b1);
        send_rx(8'h55, 1'b1);
        repeat (5) @(negedge clk);
        read_expect("stat_overrun", 13'h8, 32'h27);
        read_expect("rx_ovf0", 13'h0, 32'h11);
        read_expect("rx_ovf1", 13'h0, 32'h22);
        read_expect("rx_ovf2", 13'h0, 32'h33);
        read_expect("rx_ovf3", 13'h0, 32'h44);
        read_expect("rx_empty_read", 13'h0, 32'h00);
        read_expect("stat_after_drain", 13'h8, 32'h04);

        send_rx(8'h5A, 1'b1);
        repeat (5) @(negedge clk);
        read_expect("stat_before_rx_flush", 13'h8, 32'h05);
        write_ok(13'hC, 32'h02);
        read_expect("stat_after_rx_flush", 13'h8, 32'h04);

        // Hold bready low while a second write waits.
        @(negedge clk);
        awaddr = 13'hC; wdata = 32'h0; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        n = 0;
        while (!bvalid && n < WAIT_MAX) begin @(negedge clk); n++; end
        ok = bvalid;
        for (int i = 0; i < 20; i++) begin
            if (!bvalid || awready) ok = 1'b0;
            @(negedge clk);
        end
        check("bvalid_held_no_awready", ok, 1);
        bready = 1'b1;
        n = 0;
        while (!awready && n < WAIT_MAX) begin @(negedge clk); n++; end
        check("second_write_accepted", awready, 1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        repeat (3) @(negedge clk);
        check("second_write_done", bvalid, 0);

        @(negedge clk);
        awaddr = 13'h4; wdata = 32'h77; awvalid = 1'b1; wvalid = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (awready || wready) ok = 1'b0;
            @(negedge clk);
        end
        awvalid = 1'b0;
        check("aw_without_w", ok, 1);
        read_expect("stat_no_push", 13'h8, 32'h04);

        // TX flush mid-frame: first byte finishes, queued bytes vanish.
        write_ok(13'h4, 32'h01);
        write_ok(13'h4, 32'h02);
        write_ok(13'h4, 32'h03);
        write_ok(13'hC, 32'h01);
        read_expect("stat_tx_flushed", 13'h8, 32'h04);
        repeat (200) @(negedge clk);
        ok = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (!uart_tx) ok = 1'b0;
            @(negedge clk);
        end
        check("tx_idle_after_flush", ok, 1);
        read_expect("stat_tx_flush_done", 13'h8, 32'h84);

        // Reset in the middle of TX and RX frames.
        write_ok(13'h4, 32'h00);
        n = 0;
        while (uart_tx && n < WAIT_MAX) begin @(negedge clk); n++; end
        uart_rx = 1'b0;
        repeat (30) @(negedge clk);
        check("tx_low_mid_frame", uart_tx, 0);
        rst_n = 1'b0;
        uart_rx = 1'b1;
        @(negedge clk);
        check("tx_high_after_reset", uart_tx, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        read_expect("stat_after_mid_reset", 13'h8, 32'h04);
        check("irq_after_mid_reset", uart_irq, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
